// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU sequencer: opcode and sequencer state
// encodings, plus the opcode class helper used for carry handling.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_NOT  = 3'b000,
    ALU_AND  = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_ADD  = 3'b100,
    ALU_SUB  = 3'b101,
    ALU_RSV6 = 3'b110,
    ALU_RSV7 = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam alu_op_t OP_ADD = ALU_ADD;
  localparam alu_op_t OP_SUB = ALU_SUB;

  // Only ADD and SUB propagate a carry between bit positions.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: logic ops and a full adder.
// Reserved opcodes produce r=0, cout=0.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       r,
  output logic       cout
);

  always_comb begin
    r    = 1'b0;
    cout = 1'b0;
    case (op)
      ALU_NOT: r = ~a;
      ALU_AND: r = a & b;
      ALU_XOR: r = a ^ b;
      ALU_OR:  r = a | b;
      ALU_ADD, ALU_SUB: begin
        r    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
      end
      default: begin
        r    = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: accepts a WIDTH-bit request, runs it through one
// 1-bit slice LSB first over WIDTH cycles, then holds the result until taken.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE and the
// result stays stable until out_ready is seen.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int IW = $clog2(WIDTH);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic             w_bit_b;
  logic             w_slice_r;
  logic             w_slice_cout;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_final;

  assign w_accept     = in_valid && (r_state == IDLE);
  assign w_last       = (r_idx == IW'(WIDTH - 1));
  assign w_bit_b      = (r_op == OP_SUB) ? ~r_b[0] : r_b[0];
  assign w_carry_next = is_arith(r_op) ? w_slice_cout : 1'b0;
  // Result bits shift in from the top so bit idx lands at position idx after
  // the last RUN cycle.
  assign w_final      = {w_slice_r, r_acc[WIDTH-1:1]};

  alu_bit_slice u_slice (
    .a    (r_a[0]),
    .b    (w_bit_b),
    .cin  (r_carry),
    .op   (r_op),
    .r    (w_slice_r),
    .cout (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next_state = RUN;
      end
      RUN: begin
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_op    <= op;
      r_carry <= (op == OP_ADD) ? cin : (op == OP_SUB);
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_acc   <= w_final;
      r_carry <= w_carry_next;
      r_idx   <= r_idx + IW'(1);
      if (w_last) begin
        r_result <= w_final;
        r_cout   <= w_carry_next;
        r_zero   <= (w_final == '0);
      end
    end
  end

  assign result    = r_result;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: directed scenarios plus random ops,
// scored against an arithmetic reference model through an expected queue.
module tb_alu_serial_seq;

  localparam int WIDTH = 4;
  localparam int RW    = WIDTH + 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             busy;
  logic [1:0]       dbg_state;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: {cout, zero, result} from plain modular arithmetic.
  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                          input logic mc, input logic [2:0] mop);
    longint unsigned m, va, vb, s;
    logic [WIDTH-1:0] res;
    logic             co;
    m   = longint'(1) << WIDTH;
    va  = longint'(ma);
    vb  = longint'(mb);
    res = '0;
    co  = 1'b0;
    case (mop)
      3'd0: res = ~ma;
      3'd1: res = ma & mb;
      3'd2: res = ma ^ mb;
      3'd3: res = ma | mb;
      3'd4: begin
        s   = va + vb + longint'(mc);
        res = WIDTH'(s % m);
        co  = (s >= m);
      end
      3'd5: begin
        s   = (va + m - vb) % m;
        res = WIDTH'(s);
        co  = (va >= vb);
      end
      default: begin
        res = '0;
        co  = 1'b0;
      end
    endcase
    return {co, (res == '0), res};
  endfunction

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int            acc_q[$];
  int            acc_log[$];
  logic          prev_ov = 1'b0;

  always @(negedge clk) begin
    logic [RW-1:0] e;
    int            t;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) check("latency_no_request", 1, 0);
        else begin
          t = acc_q.pop_front();
          check("latency", 64'(cyc - t - 1), 64'(WIDTH));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("result_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("result", 64'(result), 64'(e[WIDTH-1:0]));
          check("zero", 64'(zero), 64'(e[WIDTH]));
          check("cout", 64'(cout), 64'(e[WIDTH+1]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, op));
        acc_q.push_back(cyc);
        acc_log.push_back(cyc);
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic tc, input logic [2:0] top);
    @(posedge clk);
    #1;
    a = ta; b = tb_v; cin = tc; op = top; in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    // Operand changes after acceptance must not disturb the in-flight op.
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); op = 3'($urandom);
  endtask

  task automatic wait_idle(input bit rand_ready);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rand_ready) begin
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
    out_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_result"},    64'(result),    64'd0);
    check({tag, "_cout"},      64'(cout),      64'd0);
    check({tag, "_zero"},      64'(zero),      64'd0);
    check({tag, "_state"},     64'(dbg_state), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed arithmetic and logic cases.
    issue(4'b0111, 4'b1001, 1'b0, 3'b100); wait_idle(0);
    issue(4'b0101, 4'b0011, 1'b1, 3'b101); wait_idle(0);
    issue(4'b0011, 4'b0101, 1'b0, 3'b101); wait_idle(0);
    for (int k = 0; k < 8; k++) begin
      issue(4'b1100, 4'b1010, 1'b1, 3'(k)); wait_idle(0);
    end

    // Backpressure: result held while out_ready=0, new request refused.
    out_ready = 1'b0;
    issue(4'b1011, 4'b0110, 1'b1, 3'b100);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("bp_valid_timeout", 0, 1);
    #1;
    a = 4'b1111; b = 4'b0101; cin = 1'b0; op = 3'b001; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_result",    64'(result),    64'(4'b0010));
      check("bp_cout",      64'(cout),      64'd1);
      check("bp_zero",      64'(zero),      64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready",  64'(in_ready),  64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle(0);

    // Reset in the middle of RUN aborts the operation.
    issue(4'b0011, 4'b0100, 1'b0, 3'b100);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(4'b0001, 4'b0001, 1'b0, 3'b100); wait_idle(0);
    check("post_reset_result", 64'(result), 64'(4'b0010));
    check("post_reset_cout",   64'(cout),   64'd0);

    // Back-to-back with in_valid held high.
    @(posedge clk);
    #1;
    a = 4'b0011; b = 4'b0101; cin = 1'b0; op = 3'b100; in_valid = 1'b1;
    wait_accept();
    a = 4'b1000; b = 4'b0001; cin = 1'b0; op = 3'b101;
    wait_accept();
    in_valid = 1'b0;
    wait_idle(0);
    if (acc_log.size() >= 2)
      check("b2b_spacing", 64'(acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2]), 64'(WIDTH + 2));
    else
      check("b2b_accepts", 64'(acc_log.size()), 64'd2);

    // Random ops with random consumer backpressure.
    for (int n = 0; n < 40; n++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 3'($urandom_range(0, 7)));
      wait_idle(1);
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
